// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the lab RISC-V datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on memory ready, traps on illegal opcodes or timeouts.
module multicycle_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [31:0]      instr,
   input  logic             eq,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             reg_write,
   output logic             alu_src,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       imm_src,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             result_src,
   output logic [2:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
   localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

   state_t             cur_state, nxt_state;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]   instret_q;
   logic               retire, waiting, ready_now, timed_out, in_instr;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       is_addi, is_add, is_sub, is_beq, is_bne, is_lw, is_sw;
   logic       is_branch, is_mem, legal;
   logic       unused_instr_bits;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

   assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
   assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
   assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
   assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
   assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
   assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);

   assign is_branch = is_beq | is_bne;
   assign is_mem    = is_lw | is_sw;
   assign legal     = is_addi | is_add | is_sub | is_branch | is_mem;

   assign state   = cur_state;
   assign halted  = (cur_state == S_TRAP);
   assign instret = instret_q;

   // Decode fields are only driven while an instruction is in flight.
   assign in_instr = (cur_state == S_DECODE) || (cur_state == S_EXEC) ||
                     (cur_state == S_MEM)    || (cur_state == S_WB);
   assign alu_src  = in_instr & (is_addi | is_mem);
   assign alu_ctrl = (in_instr & (is_sub | is_branch)) ? 3'b001 : 3'b000;
   assign imm_src  = !in_instr ? 2'b00 : is_sw ? 2'b01 : is_branch ? 2'b10 : 2'b00;

   // Handshake: a request is held every cycle until the matching ready is seen high in
   // the same cycle; ready with no request is ignored. Ready beats a coincident timeout.
   always_comb begin
      waiting   = ((cur_state == S_FETCH) && run) || (cur_state == S_MEM);
      ready_now = (cur_state == S_MEM) ? dmem_ready : imem_ready;
      timed_out = (TIMEOUT > 0) && waiting && !ready_now && (wait_cnt == WAIT_LAST);
   end

   always_comb begin
      nxt_state  = cur_state;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      result_src = 1'b0;
      retire     = 1'b0;
      case (cur_state)
         S_FETCH: begin
            if (run) begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we     = 1'b1;
                  nxt_state = S_DECODE;
               end else if (timed_out) begin
                  nxt_state = S_TRAP;
               end
            end
         end
         S_DECODE: nxt_state = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (is_branch) begin
               pc_we     = 1'b1;
               pc_src    = is_beq ? eq : ~eq;
               retire    = 1'b1;
               nxt_state = S_FETCH;
            end else if (is_mem) begin
               nxt_state = S_MEM;
            end else begin
               nxt_state = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            if (dmem_ready) begin
               if (is_sw) begin
                  pc_we     = 1'b1;
                  retire    = 1'b1;
                  nxt_state = S_FETCH;
               end else begin
                  nxt_state = S_WB;
               end
            end else if (timed_out) begin
               nxt_state = S_TRAP;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            result_src = is_lw;
            pc_we      = 1'b1;
            retire     = 1'b1;
            nxt_state  = S_FETCH;
         end
         S_TRAP:  nxt_state = S_TRAP;
         default: nxt_state = S_TRAP;
      endcase
      if (rst) begin
         imem_req  = 1'b0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         reg_write = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         retire    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= S_FETCH;
         instret_q <= '0;
         wait_cnt  <= '0;
      end else begin
         cur_state <= nxt_state;
         if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
         end
         if ((nxt_state != cur_state) || !waiting) begin
            wait_cnt <= '0;
         end else if (!ready_now && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end

endmodule
